// File: rtl/bus_reg_select_pkg.sv
// Shared widths, IR field positions and the register one-hot decode for the
// bus receive / register select block.
package bus_reg_select_pkg;

    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 16;
    localparam int IDX_W    = 4;
    localparam int C_W      = 19;
    localparam int OPC_W    = 5;

    localparam int OPC_MSB = 31;
    localparam int RA_MSB  = 26;
    localparam int RB_MSB  = 22;
    localparam int RC_MSB  = 18;
    localparam int C_MSB   = 18;

    function automatic logic [NUM_REGS-1:0] onehot16(input logic [IDX_W-1:0] idx);
        onehot16      = '0;
        onehot16[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/bus_reg_select_if.sv
// Control/data bundle between the control unit / bus mux and bus_reg_select.
interface bus_reg_select_if
    import bus_reg_select_pkg::*;
();

    logic [DATA_W-1:0]   BusMuxOut;
    logic                IRin;
    logic                Gra;
    logic                Grb;
    logic                Grc;
    logic                Rin;
    logic                Rout;
    logic                BAout;
    logic [DATA_W-1:0]   IR;
    logic [OPC_W-1:0]    opcode;
    logic [NUM_REGS-1:0] Rout_en;
    logic [DATA_W-1:0]   RegData;
    logic [DATA_W-1:0]   C_sign_extended;
    logic                sel_err;

    modport master (
        output BusMuxOut, IRin, Gra, Grb, Grc, Rin, Rout, BAout,
        input  IR, opcode, Rout_en, RegData, C_sign_extended, sel_err
    );

    modport slave (
        input  BusMuxOut, IRin, Gra, Grb, Grc, Rin, Rout, BAout,
        output IR, opcode, Rout_en, RegData, C_sign_extended, sel_err
    );

endinterface

// File: rtl/bus_reg_select_reg_file_16x32.sv
// 16 x 32 general register file: one indexed write port, one combinational
// read port on the same index, contents cleared asynchronously by clr.
module reg_file_16x32
    import bus_reg_select_pkg::*;
(
    input  logic              clk,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0]   regs_reg [NUM_REGS];
    logic [NUM_REGS-1:0] wr_sel;

    assign wr_sel = wr_en ? onehot16(idx) : '0;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < NUM_REGS; i++) regs_reg[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_sel[i]) regs_reg[i] <= wr_data;
            end
        end
    end

    // Old value is visible during the write cycle; no write-through.
    assign rd_data = regs_reg[idx];

endmodule

// File: rtl/bus_reg_select.sv
// Bus receive end: IR capture, Gra/Grb/Grc register select, register file
// access, out-enable decode, sign-extended constant and sticky select error.
module bus_reg_select
    import bus_reg_select_pkg::*;
(
    input  logic            clk,
    input  logic            clr,
    bus_reg_select_if.slave bus
);

    logic [DATA_W-1:0] ir_reg;
    logic              sel_err_reg;
    logic              sel_err_next;
    logic [IDX_W-1:0]  ra;
    logic [IDX_W-1:0]  rb;
    logic [IDX_W-1:0]  rc;
    logic [IDX_W-1:0]  sel;
    logic              any_g;
    logic              multi_g;
    logic              wr_en;
    logic [DATA_W-1:0] rd_data;

    assign ra = ir_reg[RA_MSB -: IDX_W];
    assign rb = ir_reg[RB_MSB -: IDX_W];
    assign rc = ir_reg[RC_MSB -: IDX_W];

    always_comb begin
        sel = '0;
        if (bus.Gra)      sel = ra;
        else if (bus.Grb) sel = rb;
        else if (bus.Grc) sel = rc;
    end

    assign any_g   = bus.Gra | bus.Grb | bus.Grc;
    assign multi_g = (bus.Gra & bus.Grb) | (bus.Gra & bus.Grc) | (bus.Grb & bus.Grc);
    assign wr_en   = bus.Rin & any_g;

    // Flag is informational only; the priority-selected write still happens.
    assign sel_err_next = sel_err_reg | multi_g | (bus.Rin & ~any_g);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            ir_reg      <= '0;
            sel_err_reg <= 1'b0;
        end else begin
            if (bus.IRin) ir_reg <= bus.BusMuxOut;
            sel_err_reg <= sel_err_next;
        end
    end

    reg_file_16x32 u_reg_file (
        .clk     (clk),
        .clr     (clr),
        .wr_en   (wr_en),
        .idx     (sel),
        .wr_data (bus.BusMuxOut),
        .rd_data (rd_data)
    );

    assign bus.IR              = ir_reg;
    assign bus.opcode          = ir_reg[OPC_MSB -: OPC_W];
    assign bus.Rout_en         = (bus.Rout | bus.BAout) ? onehot16(sel) : '0;
    // R0 used as a base address reads as zero.
    assign bus.RegData         = (bus.BAout && sel == '0) ? '0 : rd_data;
    assign bus.C_sign_extended = {{(DATA_W-C_W){ir_reg[C_MSB]}}, ir_reg[C_MSB:0]};
    assign bus.sel_err         = sel_err_reg;

endmodule
